// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Initiator for the shared 64-bit memory bus. It accepts one load or store
//   at a time from the core, holds the bus strobes for WAIT_CYCLES+1 cycles,
//   then returns a one-cycle response with a size-extended load result.
//
// Ports
//   clock, reset                 clock; asynchronous active-high reset
//   req_valid / req_ready        request handshake from the core
//   req_write, req_addr,         request fields: store flag, byte address,
//   req_size, req_signed,        size code (00 b, 01 h, 10 w, 11 d),
//   req_wdata                    sign-extend flag, right-aligned store data
//   resp_valid                   one-cycle completion pulse
//   resp_rdata, resp_error       result and misalignment flag, held between pulses
//   bus_address, bus_size        bus address/size, 0 outside ACCESS
//   bus_mem_read, bus_mem_write  bus strobes, high only in ACCESS
//   bus_data                     shared data lines, driven only for a write in ACCESS
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE. resp_valid has no
// backpressure; the consumer must take it in the cycle it is high.
module mem_bus_master #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_WIDTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] bus_address,
  output logic [1:0]  bus_size,
  output logic        bus_mem_read,
  output logic        bus_mem_write,
  inout  wire  [63:0] bus_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                 write_q;
  logic [31:0]          addr_q;
  logic [1:0]           size_q;
  logic                 signed_q;
  logic [63:0]          wdata_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic accept;
  logic in_access;
  logic misaligned;

  // Address must be a multiple of the access size in bytes.
  function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] sz);
    logic r;
    r = 1'b0;
    case (sz)
      2'b00: r = 1'b0;
      2'b01: r = a[0];
      2'b10: r = (a[1:0] != 2'b00);
      2'b11: r = (a[2:0] != 3'b000);
    endcase
    return r;
  endfunction

  // Keep the low 8*2**sz bits; fill above with zeros or the top valid bit.
  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                         input logic sg);
    logic [63:0] r;
    r = d;
    case (sz)
      2'b00: r = {{56{sg & d[7]}},  d[7:0]};
      2'b01: r = {{48{sg & d[15]}}, d[15:0]};
      2'b10: r = {{32{sg & d[31]}}, d[31:0]};
      2'b11: r = d;
    endcase
    return r;
  endfunction

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready;
  assign misaligned = is_misaligned(req_addr, req_size);
  assign in_access  = (state == ACCESS);
  assign resp_valid = (state == RESP);

  // Bus outputs are derived from state so an asynchronous reset drops the
  // strobes and releases bus_data in the same cycle.
  assign bus_mem_read  = in_access & ~write_q;
  assign bus_mem_write = in_access & write_q;
  assign bus_address   = in_access ? addr_q : 32'd0;
  assign bus_size      = in_access ? size_q : 2'd0;
  assign bus_data      = (in_access & write_q) ? wdata_q : 64'bz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = misaligned ? RESP : ACCESS;
      ACCESS:  if (cnt_q == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      wdata_q    <= 64'd0;
      cnt_q      <= '0;
      resp_rdata <= 64'd0;
      resp_error <= 1'b0;
    end else if (accept) begin
      write_q  <= req_write;
      addr_q   <= req_addr;
      size_q   <= req_size;
      signed_q <= req_signed;
      wdata_q  <= req_wdata;
      cnt_q    <= CNT_WIDTH'(WAIT_CYCLES);
      if (misaligned) begin
        resp_rdata <= 64'd0;
        resp_error <= 1'b1;
      end
    end else if (in_access) begin
      if (cnt_q == '0) begin
        // Last strobe cycle: the responder's read data is valid on this edge.
        resp_error <= 1'b0;
        resp_rdata <= write_q ? 64'd0 : extend(bus_data, size_q, signed_q);
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master
//   Directed bench for mem_bus_master with WAIT_CYCLES=1. A small bus model
//   drives bus_data whenever the read strobe is high.
module tb_mem_bus_master;

  localparam int WAIT = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [31:0] bus_address;
  logic [1:0]  bus_size;
  logic        bus_mem_read;
  logic        bus_mem_write;
  wire  [63:0] bus_data;
  logic [63:0] model_data;

  int total = 0;
  int bad   = 0;

  mem_bus_master #(.WAIT_CYCLES(WAIT), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .bus_address(bus_address), .bus_size(bus_size),
    .bus_mem_read(bus_mem_read), .bus_mem_write(bus_mem_write),
    .bus_data(bus_data)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Responder model: drives read data only while the read strobe is high.
  assign bus_data = bus_mem_read ? model_data : 64'bz;

  // Released bus reads as z in a 4-state simulator and as 0 in a 2-state one.
  function automatic logic bus_released();
    return $isunknown(bus_data) || (bus_data == 64'd0);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request, follow it to its response and check the bus activity.
  task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [1:0] sz, input logic sg, input logic [63:0] wd,
                         input logic [63:0] rd_model, input logic [63:0] exp_rdata,
                         input logic exp_err);
    int n_rd, n_wr, resp_at, bus_bad;
    int exp_strobe;
    n_rd = 0; n_wr = 0; resp_at = 0; bus_bad = 0;
    exp_strobe = exp_err ? 0 : WAIT + 1;
    model_data = rd_model;
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10 && resp_at == 0; c++) begin
      if (bus_mem_read) n_rd++;
      if (bus_mem_write) begin
        n_wr++;
        if (bus_data !== wd) bus_bad++;
      end
      if (bus_mem_read || bus_mem_write) begin
        if (bus_address !== addr || bus_size !== sz) bus_bad++;
      end else if (!bus_released()) begin
        bus_bad++;
      end
      if (resp_valid) begin
        resp_at = c;
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {63'd0, resp_error}, {63'd0, exp_err});
      end else begin
        @(posedge clock); #1;
      end
    end
    check({tag, "_lat"}, 64'(resp_at), exp_err ? 64'd1 : 64'(WAIT + 2));
    check({tag, "_nrd"}, 64'(n_rd), (wr || exp_err) ? 64'd0 : 64'(exp_strobe));
    check({tag, "_nwr"}, 64'(n_wr), (!wr || exp_err) ? 64'd0 : 64'(exp_strobe));
    check({tag, "_bus"}, 64'(bus_bad), 64'd0);
    @(posedge clock); #1;
    check({tag, "_pulse"}, {62'd0, resp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0; model_data = '0;

    // 1. Reset state before any clock edge
    #1;
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp", {62'd0, resp_valid, resp_error}, 64'd0);
    check("rst_strobe", {62'd0, bus_mem_read, bus_mem_write}, 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_bus", {63'd0, bus_released()}, 64'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // 2. Load double
    run_req("ld_d", 1'b0, 32'h10, 2'b11, 1'b0, 64'd0,
            64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0);
    // 3. Load byte, signed and unsigned
    run_req("ld_bs", 1'b0, 32'h3, 2'b00, 1'b1, 64'd0,
            64'h80, 64'hFFFFFFFFFFFFFF80, 1'b0);
    run_req("ld_bu", 1'b0, 32'h3, 2'b00, 1'b0, 64'd0,
            64'h80, 64'h0000000000000080, 1'b0);
    // Half and word extension; upper responder bits are not trusted
    run_req("ld_hs", 1'b0, 32'h2, 2'b01, 1'b1, 64'd0,
            64'h0000000000008001, 64'hFFFFFFFFFFFF8001, 1'b0);
    run_req("ld_hu", 1'b0, 32'h6, 2'b01, 1'b0, 64'd0,
            64'hFFFF000000001234, 64'h0000000000001234, 1'b0);
    run_req("ld_ws", 1'b0, 32'h4, 2'b10, 1'b1, 64'd0,
            64'h0000000080000000, 64'hFFFFFFFF80000000, 1'b0);
    run_req("ld_ds", 1'b0, 32'h8, 2'b11, 1'b1, 64'd0,
            64'h8000000000000001, 64'h8000000000000001, 1'b0);
    // 4. Store word
    run_req("st_w", 1'b1, 32'h8, 2'b10, 1'b0, 64'hDEADBEEF,
            64'd0, 64'd0, 1'b0);
    // 5. Misaligned accesses
    run_req("mis_h", 1'b0, 32'h1, 2'b01, 1'b0, 64'd0, 64'hFFFF, 64'd0, 1'b1);
    run_req("mis_w", 1'b1, 32'h6, 2'b10, 1'b0, 64'h55, 64'd0, 64'd0, 1'b1);
    run_req("mis_d", 1'b0, 32'h4, 2'b11, 1'b0, 64'd0, 64'h1, 64'd0, 1'b1);

    // 6. Reset during the first ACCESS cycle of a load
    model_data = 64'h1111;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_size = 2'b11;
    req_signed = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("abort_pre", {63'd0, bus_mem_read}, 64'd1);
    reset = 1'b1;
    #1;
    check("abort_strobe", {62'd0, bus_mem_read, bus_mem_write}, 64'd0);
    check("abort_bus", {63'd0, bus_released()}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid) seen++;
      @(posedge clock); #1;
    end
    check("abort_noresp", 64'(seen), 64'd0);
    run_req("post_abort", 1'b0, 32'h18, 2'b10, 1'b0, 64'd0,
            64'h00000000CAFEF00D, 64'h00000000CAFEF00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
